// File: rtl/sw_debounce_sync.sv
// ----------------------------------------------------------------------------
// sw_debounce_sync
//
// Conditions raw slide-switch levels before they reach the switch-selected
// LED counter stage. Each channel passes through a two-flop synchronizer and
// then a debounce counter; the debounced level only changes after the
// synchronized input has disagreed with it for DEBOUNCE_CYCLES consecutive
// clocks. Any single agreeing cycle restarts the count.
//
// Parameters
//   WIDTH            number of switch channels
//   DEBOUNCE_CYCLES  consecutive disagreeing cycles required (>= 1)
//   CNT_W            debounce counter width, derived from DEBOUNCE_CYCLES
//
// Ports
//   clk        in   system clock, all state updates on the rising edge
//   reset      in   synchronous reset, active-high
//   sw_in      in   raw asynchronous switch levels
//   sw_out     out  debounced, synchronized switch levels (registered)
//   sw_rise    out  one-cycle pulse per bit when sw_out goes 0->1
//   sw_fall    out  one-cycle pulse per bit when sw_out goes 1->0
//   sw_onehot  out  high when exactly one bit of sw_out is set
// ----------------------------------------------------------------------------
module sw_debounce_sync #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_onehot
);

    // Terminal count: the update happens on the edge where the counter already
    // holds DEBOUNCE_CYCLES-1, so the counter itself never exceeds that value.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;

    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] fall_d;

    // ------------------------------------------------------------------------
    // Per-channel debounce next-state. Channels never interact.
    // ------------------------------------------------------------------------
    always_comb begin
        out_d  = out_q;
        rise_d = '0;
        fall_d = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == out_q[i]) begin
                // Agreement (including a bounce back) discards the count.
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                out_d[i]  = sync2_q[i];
                cnt_d[i]  = '0;
                rise_d[i] = sync2_q[i];
                fall_d[i] = ~sync2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // State registers; reset has priority over every update.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            out_q   <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= sw_in;
            sync2_q <= sync1_q;
            out_q   <= out_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. sw_onehot decodes only registered state, so no path exists
    // from sw_in to any output. x & (x-1) clears the lowest set bit, leaving
    // zero exactly when at most one bit was set.
    // ------------------------------------------------------------------------
    always_comb begin
        sw_onehot = (out_q != '0) && ((out_q & (out_q - WIDTH'(1))) == '0);
    end

    assign sw_out  = out_q;
    assign sw_rise = rise_q;
    assign sw_fall = fall_q;

endmodule
